// File: rtl/sample_feeder.sv
// ============================================================================
// sample_feeder : stores labelled (x1, x2, t) samples and serves them one per
//                 controller request in a repeating epoch.
// Optional: `define FEEDER_ERR_CNT_EN adds an 8-bit saturating errCnt output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_feeder #(
  parameter int DEPTH = 64,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          loadEn,
  input  logic [DW-1:0] x1In,
  input  logic [DW-1:0] x2In,
  input  logic          tIn,
  input  logic          clear,
  input  logic          start,
  input  logic          readyToGetData,
  input  logic          doneSignal,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic [DW-1:0] t,
  output logic          dataValid,
  output logic [32:0]   nBus,
  output logic          epochWrap,
  output logic          loadErr,
  output logic          busy
`ifdef FEEDER_ERR_CNT_EN
  ,
  output logic [7:0]    errCnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] rd_ptr, rd_ptr_nxt;
  logic          wr_en, rd_en, wrap, err_nxt;

  logic [DW-1:0] x1_mem [DEPTH];
  logic [DW-1:0] x2_mem [DEPTH];
  logic          t_mem  [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state  <= IDLE;
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    wrap       = 1'b0;
    err_nxt    = 1'b0;
    if (clear) begin
      state_nxt  = IDLE;
      count_nxt  = '0;
      rd_ptr_nxt = '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (loadEn) begin
            if (count == FULL) begin
              err_nxt = 1'b1;
            end else begin
              wr_en     = 1'b1;
              count_nxt = count + CW'(1);
              state_nxt = LOAD;
            end
          end
          // An empty store can never be served, so start only acts from LOAD
          if (start && state == LOAD) begin
            state_nxt  = SERVE;
            rd_ptr_nxt = '0;
          end
        end
        SERVE: begin
          if (loadEn) err_nxt = 1'b1;
          if (doneSignal) begin
            state_nxt  = LOAD;
            rd_ptr_nxt = '0;
          end else if (readyToGetData) begin
            rd_en = 1'b1;
            if ({1'b0, rd_ptr} == count - CW'(1)) begin
              wrap       = 1'b1;
              rd_ptr_nxt = '0;
            end else begin
              rd_ptr_nxt = rd_ptr + AW'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      x1_mem[count[AW-1:0]] <= x1In;
      x2_mem[count[AW-1:0]] <= x2In;
      t_mem[count[AW-1:0]]  <= tIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      x1        <= '0;
      x2        <= '0;
      t         <= '0;
      dataValid <= 1'b0;
      epochWrap <= 1'b0;
      loadErr   <= 1'b0;
    end else begin
      dataValid <= rd_en;
      epochWrap <= wrap;
      loadErr   <= err_nxt;
      if (rd_en) begin
        x1 <= x1_mem[rd_ptr];
        x2 <= x2_mem[rd_ptr];
        t  <= t_mem[rd_ptr] ? DW'(1) : {DW{1'b1}};
      end
    end
  end

  assign nBus = {{(33-CW){1'b0}}, count};
  assign busy = (state == SERVE);

`ifdef FEEDER_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstN || clear) begin
      errCnt <= '0;
    end else if (loadErr && errCnt != 8'hFF) begin
      errCnt <= errCnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sample_feeder.sv
// Scoreboard bench for sample_feeder: requests push expected samples, a monitor
// pops and compares on every dataValid.
`default_nettype none

module tb_sample_feeder;

  localparam int DEPTH = 8;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          loadEn = 1'b0;
  logic [DW-1:0] x1In = '0;
  logic [DW-1:0] x2In = '0;
  logic          tIn = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          readyToGetData = 1'b0;
  logic          doneSignal = 1'b0;
  logic [DW-1:0] x1, x2, t;
  logic          dataValid, epochWrap, loadErr, busy;
  logic [32:0]   nBus;
`ifdef FEEDER_ERR_CNT_EN
  logic [7:0]    errCnt;
`endif

  sample_feeder #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rstN(rstN), .loadEn(loadEn), .x1In(x1In), .x2In(x2In),
    .tIn(tIn), .clear(clear), .start(start), .readyToGetData(readyToGetData),
    .doneSignal(doneSignal), .x1(x1), .x2(x2), .t(t), .dataValid(dataValid),
    .nBus(nBus), .epochWrap(epochWrap), .loadErr(loadErr), .busy(busy)
`ifdef FEEDER_ERR_CNT_EN
    , .errCnt(errCnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int x1;
    int x2;
    int t;
    bit wrap;
    int due;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every dataValid must match the oldest outstanding request
  always @(negedge clk) begin
    if (dataValid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_dataValid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_x1", $signed(x1), e.x1);
        chk("sb_x2", $signed(x2), e.x2);
        chk("sb_t", $signed(t), e.t);
        chk("sb_epochWrap", epochWrap, e.wrap);
        chk("sb_latency", cyc, e.due);
      end
    end else if (epochWrap === 1'b1) begin
      chk("epochWrap_without_dataValid", 1, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int b, input bit tt);
    loadEn = 1'b1;
    x1In   = a[DW-1:0];
    x2In   = b[DW-1:0];
    tIn    = tt;
    tick();
    loadEn = 1'b0;
  endtask

  task automatic expect_sample(input int a, input int b, input int tv, input bit w, input int lat);
    exp_t e;
    e.x1 = a; e.x2 = b; e.t = tv; e.wrap = w; e.due = cyc + lat;
    q.push_back(e);
  endtask

  task automatic req(input int a, input int b, input int tv, input bit w);
    expect_sample(a, b, tv, w, 1);
    readyToGetData = 1'b1;
    tick();
    readyToGetData = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_x1"}, x1, 0);
    chk({tag, "_x2"}, x2, 0);
    chk({tag, "_t"}, t, 0);
    chk({tag, "_dataValid"}, dataValid, 0);
    chk({tag, "_epochWrap"}, epochWrap, 0);
    chk({tag, "_loadErr"}, loadErr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nBus"}, nBus, 0);
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk_zero_outputs("reset");
    rstN = 1'b1;

    // start with nothing stored is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("idle_start_busy", busy, 0);

    // Three-sample epoch
    load(5, -2, 1'b1);
    load(-7, 4, 1'b0);
    load(0, 9, 1'b1);
    chk("load3_nBus", nBus, 3);
    chk("load3_busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("serve_busy", busy, 1);
    req(5, -2, 1, 1'b0);
    tick();
    chk("hold_x1", $signed(x1), 5);
    chk("hold_t", $signed(t), 1);
    req(-7, 4, -1, 1'b0); tick();
    req(0, 9, 1, 1'b1);   tick();
    req(5, -2, 1, 1'b0);  tick();
    chk("serve_nBus", nBus, 3);

    // doneSignal drops a simultaneous request and rewinds
    doneSignal = 1'b1; readyToGetData = 1'b1; tick();
    doneSignal = 1'b0; readyToGetData = 1'b0;
    chk("done_busy", busy, 0);
    readyToGetData = 1'b1; tick(); readyToGetData = 1'b0;
    chk("ready_in_load_x1", $signed(x1), 5);
    start = 1'b1; tick(); start = 1'b0;
    req(5, -2, 1, 1'b0);

    // loadEn while serving is rejected
    loadEn = 1'b1; x1In = 16'd77; tick(); loadEn = 1'b0;
    chk("serve_load_loadErr", loadErr, 1);
    chk("serve_load_nBus", nBus, 3);
    tick();
    chk("loadErr_pulse_end", loadErr, 0);
`ifdef FEEDER_ERR_CNT_EN
    chk("errCnt_one", errCnt, 1);
`endif

    // Reset mid-epoch
    req(-7, 4, -1, 1'b0);
    rstN = 1'b0; tick(); rstN = 1'b1;
    chk_zero_outputs("midreset");
`ifdef FEEDER_ERR_CNT_EN
    chk("midreset_errCnt", errCnt, 0);
`endif
    start = 1'b1; tick(); start = 1'b0;
    chk("post_reset_start_busy", busy, 0);

    // clear dominates a request
    load(11, -3, 1'b1);
    load(-1, 2, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    readyToGetData = 1'b1; clear = 1'b1; tick();
    readyToGetData = 1'b0; clear = 1'b0;
    chk("clear_nBus", nBus, 0);
    chk("clear_busy", busy, 0);
    chk("clear_dataValid", dataValid, 0);

    // start together with the last write; back-to-back requests
    load(100, -100, 1'b0);
    start = 1'b1; loadEn = 1'b1; x1In = 16'd7; x2In = 16'd8; tIn = 1'b1;
    tick();
    start = 1'b0; loadEn = 1'b0;
    chk("start_load_nBus", nBus, 2);
    chk("start_load_busy", busy, 1);
    expect_sample(100, -100, -1, 1'b0, 1);
    expect_sample(7, 8, 1, 1'b1, 2);
    readyToGetData = 1'b1; tick(); tick(); readyToGetData = 1'b0;
    tick();

    // Fill to capacity, then overflow
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) load(i * 3 - 10, 20 - i, i[0]);
    chk("full_nBus", nBus, DEPTH);
    loadEn = 1'b1; x1In = 16'h1234; tick(); loadEn = 1'b0;
    chk("full_loadErr", loadErr, 1);
    chk("full_nBus_after", nBus, DEPTH);
    tick();
`ifdef FEEDER_ERR_CNT_EN
    chk("full_errCnt", errCnt, 1);
`endif
    start = 1'b1; tick(); start = 1'b0;
    req(-10, 20, -1, 1'b0);
    tick(); tick();

    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter DEPTH, default 64: sample storage capacity in entries; power of two, 2..1024.
REQ-002 Parameter DW, default 16: width of x1/x2 samples, signed two's complement.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rstN  input  1  reset, synchronous, active-low.
REQ-005 loadEn  input  1  write one sample (x1In, x2In, tIn) this cycle.
REQ-006 x1In, x2In  input  DW each  sample features to store.
REQ-007 tIn  input  1  target class: 1 = +1, 0 = -1.
REQ-008 clear  input  1  discard all stored samples.
REQ-009 start  input  1  begin serving (same pulse that starts the training controller).
REQ-010 readyToGetData  input  1  controller request for the next sample.
REQ-011 doneSignal  input  1  controller finished training; stop serving.
REQ-012 x1, x2  output  DW each  current sample features, registered.
REQ-013 t  output  DW  current target, sign-extended: +1 or -1.
REQ-014 dataValid  output  1  one-cycle pulse: x1/x2/t updated this cycle.
REQ-015 nBus  output  33  stored sample count, zero-extended.
REQ-016 epochWrap  output  1  one-cycle pulse, coincident with dataValid, when the last stored sample is served.
REQ-017 loadErr  output  1  one-cycle pulse: a write was rejected.
REQ-018 busy  output  1  high in SERVE.

Function
REQ-019 FSM states: IDLE (count==0), LOAD (count>0, not serving), SERVE.
REQ-020 IDLE/LOAD: loadEn with count<DEPTH writes entry [count], count+1, state LOAD next cycle.
REQ-021 loadEn with count==DEPTH: no write, count unchanged, loadErr=1 the next cycle.
REQ-022 start in LOAD: enter SERVE, rdPtr<=0; start in IDLE: ignored, stays IDLE.
REQ-023 SERVE: readyToGetData at edge k -> x1/x2/t = entry[rdPtr] and dataValid=1 in cycle k+1 (1-cycle latency); rdPtr+1.
REQ-024 rdPtr==count-1 on request: rdPtr wraps to 0, epochWrap=1 with that dataValid.
REQ-025 readyToGetData in two consecutive cycles: two consecutive samples served, no drop.
REQ-026 readyToGetData outside SERVE: ignored, outputs hold, no dataValid.
REQ-027 loadEn in SERVE: no write, loadErr=1 next cycle.
REQ-028 doneSignal in SERVE: return to LOAD, data kept, rdPtr<=0; a simultaneous readyToGetData is dropped.
REQ-029 clear in any state: count<=0, rdPtr<=0, state IDLE; clear dominates loadEn, start, readyToGetData and doneSignal in the same cycle.
REQ-030 start and loadEn in the same LOAD cycle: the write completes, then SERVE; nBus includes the new sample.
REQ-031 x1/x2/t hold their last value between dataValid pulses.
REQ-032 nBus is stable throughout SERVE.

Reset
REQ-033 rstN=0 at a clock edge: state IDLE, count=0, rdPtr=0, x1=x2=t=0, dataValid=epochWrap=loadErr=0, busy=0.
REQ-034 Reset asserted mid-SERVE: aborts serving immediately; stored contents are don't-care and are not readable.
REQ-035 Storage array is not reset.

Configuration
REQ-036 With FEEDER_ERR_CNT_EN defined: output errCnt[7:0] counts loadErr pulses, saturates at 255, and is cleared by reset or clear.
REQ-037 Without FEEDER_ERR_CNT_EN: no errCnt port, no counter logic.

Verification
REQ-038 Load 3 samples (5,-2,+1), (-7,4,-1), (0,9,+1); start; 4 requests -> dataValid x4, samples 0,1,2,0; epochWrap on the 3rd only; t = 1, -1, 1, 1; nBus=3.
REQ-039 Load DEPTH samples, one more loadEn -> loadErr pulse, nBus=DEPTH; errCnt=1 if enabled.
REQ-040 Request then request back-to-back with count=2 -> dataValid 2 consecutive cycles, second with epochWrap.
REQ-041 SERVE mid-epoch, rstN=0 one cycle -> all outputs zero next cycle, state IDLE; start then ignored until a load.
REQ-042 clear + readyToGetData same cycle in SERVE -> no dataValid, nBus=0, busy=0.
REQ-043 doneSignal in SERVE, then start -> first request returns sample 0.
